// File: rtl/clken_pkg.sv
// Shared types and constants for the clock-enable generator and lock sequencer.
package clken_pkg;

    // State encodings, exported so checkers can decode the debug state output.
    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_SETTLE    = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;

    // Two flops is the minimum that gives a usable MTBF on the raw lock flag.
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        WAIT_LOCK = ST_WAIT_LOCK,
        SETTLE    = ST_SETTLE,
        RUN       = ST_RUN
    } state_t;

endpackage

// File: rtl/clken_acc.sv
// One clock-enable channel: phase accumulator, active/pending increment pair
// and the registered ce strobe.
//
// Strobe semantics: load and align are single-cycle pulses sampled on the
// rising edge; there is no back-pressure, every pulse is acted on in the
// cycle it is seen.
module clken_acc
    import clken_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,      // sequencer in RUN and lock still present
    input  logic             en,       // channel run enable
    input  logic             align,    // zero the accumulator this cycle
    input  logic             load,     // capture inc_new as the pending increment
    input  logic [ACC_W-1:0] inc_new,
    output logic             ce
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] act;
    logic [ACC_W-1:0] pend;
    logic             flag;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             swap;

    assign sum   = {1'b0, acc} + {1'b0, act};
    assign carry = sum[ACC_W];

    // A pending increment only takes over at a period boundary (wrap) or when
    // the channel is not producing strobes, so no period is ever cut short.
    assign swap  = flag && (!run || !en || align || carry);

    // Accumulate while running and enabled; freeze when disabled; clear outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (!run || align) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (en) begin
            acc <= sum[ACC_W-1:0];
            ce  <= carry;
        end else begin
            ce  <= 1'b0;
        end
    end

    // Pending/active increment handover; align with load makes the new rate
    // live immediately since the accumulator restarts anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            act  <= '0;
            pend <= '0;
            flag <= 1'b0;
        end else if (load && align) begin
            act  <= inc_new;
            pend <= inc_new;
            flag <= 1'b0;
        end else begin
            if (swap) begin
                act <= pend;
            end
            if (load) begin
                pend <= inc_new;
                flag <= 1'b1;
            end else if (swap) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clken_gen.sv
// Clock-enable generator behind the DCM: synchronises the lock flag, waits for
// it to settle, then runs NUM_CH fractional-rate ce channels.
module clken_gen
    import clken_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int ACC_W         = 24,
    parameter int SETTLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    locked_in,
    input  logic [NUM_CH*ACC_W-1:0] inc,
    input  logic                    inc_load,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    phase_align,
    output logic                    ready,
    output logic [NUM_CH-1:0]       ce,
    output logic                    lock_lost,
    output logic [1:0]              dbg_state
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    state_t                 state;
    logic [CNT_W-1:0]       settle_cnt;
    logic                   run;

    assign lock_s    = sync_q[SYNC_STAGES-1];
    assign dbg_state = state;

    // Channels stop in the same cycle the synchronised lock drops, so ce is
    // forced low on the edge that also leaves RUN.
    assign run = (state == RUN) && lock_s;

    // Lock flag synchroniser: plain shift chain into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked_in};
        end
    end

    // Lock sequencer: WAIT_LOCK -> SETTLE -> RUN, any lock loss returns to WAIT_LOCK.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
        end else if (!lock_s) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
            ready      <= 1'b0;
            if (state == RUN) begin
                lock_lost <= 1'b1;
            end
        end else begin
            case (state)
                WAIT_LOCK: begin
                    settle_cnt <= '0;
                    ready      <= 1'b0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        ready      <= 1'b1;
                        state      <= RUN;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    settle_cnt <= '0;
                    ready      <= 1'b0;
                    state      <= WAIT_LOCK;
                end
            endcase
        end
    end

    // One accumulator channel per ce output.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clken_acc #(
            .ACC_W (ACC_W)
        ) u_acc (
            .clk     (clk),
            .rst     (rst),
            .run     (run),
            .en      (ch_en[g]),
            .align   (phase_align),
            .load    (inc_load),
            .inc_new (inc[g*ACC_W +: ACC_W]),
            .ce      (ce[g])
        );
    end

endmodule

// File: tb/tb_clken_gen.sv
// Directed bench for clken_gen with ACC_W=8, SETTLE_CYCLES=16, SYNC_STAGES=2.
module tb_clken_gen;

    localparam int NUM_CH = 2;
    localparam int ACC_W  = 8;
    localparam int SETTLE = 16;
    localparam int SYNCS  = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    locked_in;
    logic [NUM_CH*ACC_W-1:0] inc;
    logic                    inc_load;
    logic [NUM_CH-1:0]       ch_en;
    logic                    phase_align;
    logic                    ready;
    logic [NUM_CH-1:0]       ce;
    logic                    lock_lost;
    logic [1:0]              dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    clken_gen #(
        .NUM_CH        (NUM_CH),
        .ACC_W         (ACC_W),
        .SETTLE_CYCLES (SETTLE),
        .SYNC_STAGES   (SYNCS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .locked_in   (locked_in),
        .inc         (inc),
        .inc_load    (inc_load),
        .ch_en       (ch_en),
        .phase_align (phase_align),
        .ready       (ready),
        .ce          (ce),
        .lock_lost   (lock_lost),
        .dbg_state   (dbg_state)
    );

    // Clock and reset block
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Drive locked_in high and count edges until ready; -1 on timeout.
    task automatic lock_and_wait(output int edges, output logic ce_seen, output logic [1:0] st_at3);
        edges   = -1;
        ce_seen = 1'b0;
        st_at3  = 2'd3;
        locked_in = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            ce_seen = ce_seen | (|ce);
            if (n == 3) st_at3 = dbg_state;
            if (ready) begin
                edges = n;
                break;
            end
        end
    endtask

    int          edges;
    logic        ce_seen;
    logic [1:0]  st3;
    int          cnt0, cnt1, first0;
    logic [15:0] pat0, pat1;

    initial begin
        rst = 1'b1; locked_in = 1'b0; inc = '0; inc_load = 1'b0;
        ch_en = '0; phase_align = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_ready", ready, 0);
        check("reset_ce", ce, 0);
        check("reset_lock_lost", lock_lost, 0);
        check("reset_state", dbg_state, 0);

        // Preload ch0=64, ch1=3 before lock; the swap happens because not in RUN.
        inc = {8'd3, 8'd64}; inc_load = 1'b1; ch_en = 2'b11;
        tick();
        inc_load = 1'b0;
        tick();

        // Lock: ready after SYNC_STAGES+1+SETTLE = 19 edges, no ce before.
        lock_and_wait(edges, ce_seen, st3);
        check("lock_ready_edges", edges, 19);
        check("lock_state_settle", st3, 1);
        check("lock_no_ce", ce_seen, 0);
        check("run_state", dbg_state, 2);

        // Rate over 1024 cycles.
        cnt0 = 0; cnt1 = 0; first0 = -1;
        for (int k = 1; k <= 1024; k++) begin
            tick();
            if (ce[0]) begin
                cnt0++;
                if (first0 < 0) first0 = k;
            end
            if (ce[1]) cnt1++;
        end
        check("rate_ch0_count", cnt0, 256);
        check("rate_ch1_count", cnt1, 12);
        check("rate_ch0_first", first0, 4);

        // Retune ch0 64->128 loaded mid-period (captured at edge 3).
        pat0 = '0;
        for (int k = 1; k <= 12; k++) begin
            inc_load = (k == 3);
            inc = {8'd3, 8'd128};
            tick();
            pat0[k-1] = ce[0];
        end
        inc_load = 1'b0;
        check("retune_pattern", pat0, 16'b0000_1010_1010_1000);

        // Phase align: equal increments 32, ch1 offset by disabling it.
        inc = {8'd32, 8'd32}; inc_load = 1'b1; phase_align = 1'b1;
        tick();
        inc_load = 1'b0; phase_align = 1'b0;
        ch_en = 2'b01;
        repeat (3) tick();
        ch_en = 2'b11;
        repeat (2) tick();
        phase_align = 1'b1;
        tick();
        phase_align = 1'b0;
        check("align_ce_cleared", ce, 0);
        pat0 = '0; pat1 = '0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            pat0[k-1] = ce[0];
            pat1[k-1] = ce[1];
        end
        check("align_ch0", pat0, 16'b1000_0000_1000_0000);
        check("align_ch1", pat1, 16'b1000_0000_1000_0000);

        // Disable ch0 for 5 cycles mid-period: wrap moves from edge 8 to 13.
        pat0 = '0; pat1 = '0;
        for (int k = 1; k <= 16; k++) begin
            ch_en = (k >= 4 && k <= 8) ? 2'b10 : 2'b11;
            tick();
            pat0[k-1] = ce[0];
            pat1[k-1] = ce[1];
        end
        ch_en = 2'b11;
        check("hold_ch0", pat0, 16'b0001_0000_0000_0000);
        check("hold_ch1", pat1, 16'b1000_0000_1000_0000);

        // Boundaries: inc=2^(ACC_W-1) strobes every 2nd cycle, inc=0 never.
        inc = {8'd0, 8'd128}; inc_load = 1'b1; phase_align = 1'b1;
        tick();
        inc_load = 1'b0; phase_align = 1'b0;
        pat0 = '0; cnt1 = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            pat0[k-1] = ce[0];
            if (ce[1]) cnt1++;
        end
        check("half_rate_ch0", pat0, 16'b1010_1010_1010_1010);
        check("zero_inc_ch1", cnt1, 0);

        // Lock loss in RUN.
        locked_in = 1'b0;
        tick();
        tick();
        check("loss_ready_edge2", ready, 1);
        tick();
        check("loss_ready_edge3", ready, 0);
        check("loss_ce_edge3", ce, 0);
        check("loss_sticky", lock_lost, 1);
        check("loss_state", dbg_state, 0);

        // Relock: sequence repeats, lock_lost stays set.
        lock_and_wait(edges, ce_seen, st3);
        check("relock_ready_edges", edges, 19);
        check("relock_no_ce", ce_seen, 0);
        check("relock_lost_kept", lock_lost, 1);

        // Only reset clears lock_lost.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_clears_lost", lock_lost, 0);
        check("rst_clears_ready", ready, 0);
        check("rst_state", dbg_state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
